prbs31_seq_ctrl: RTL and testbench
==================================

Name: prbs31_seq_ctrl

Overview:
Sequencer and checker for the PRBS31 test path (polynomial x^31 + x^28 + 1).
- Accepts start/abort commands and drives a burst of burst_len PRBS31 bits on tx_bit/tx_valid.
- A self-synchronising checker on rx_bit/rx_valid acquires lock and counts bit errors.
- Sits between the pin-mapping top level (commands from ui_in, status to uo_out) and the external loopback.

Parameters:
LEN_W, 16, width of burst length and bit counter
ERR_W, 8, width of the saturating error counter
SEED, 31'h7FFF_FFFF, generator load value; must be nonzero (elaboration-time check)

Ports:
clk  in  1  clock
rst_n  in  1  reset, synchronous, active-low
ena  in  1  0 = freeze all state (hold every register); 1 = operate
start  in  1  begin burst when sampled high in IDLE; ignored otherwise
abort  in  1  terminate burst; sampled in SEED/RUN
burst_len  in  LEN_W  bits to send, captured at start
inject_err  in  1  inverts tx_bit during the cycle it is high (RUN only); LFSR unaffected
rx_bit  in  1  looped-back data bit
rx_valid  in  1  rx_bit qualifier
tx_bit  out  1  generated PRBS bit
tx_valid  out  1  high in every RUN cycle
busy  out  1  state != IDLE
done  out  1  one-cycle pulse, burst completed
locked  out  1  checker has received 31 bits since SEED
err_cnt  out  ERR_W  saturating mismatch count since SEED

Behaviour:
- Reset (rst_n low at clk edge):
  - state = IDLE; lfsr = 0; len_q = 0; bit_cnt = 0.
  - Checker history cleared and fill = 0.
  - All outputs 0.
- ena low: no register changes. Outputs reflect the held state. inject_err is still gated by RUN.
- States: IDLE, SEED, RUN, DONE. All transitions require ena = 1.
  - IDLE -> SEED on start. Captures len_q = burst_len.
  - SEED (1 cycle):
    - Loads lfsr = SEED, bit_cnt = 0.
    - Clears checker history, fill and err_cnt.
    - Next state: abort -> IDLE; else len_q == 0 -> DONE; else RUN.
  - RUN:
    - tx_valid = 1; tx_bit = lfsr[30] ^ lfsr[27] ^ inject_err.
    - Per cycle: lfsr <= {lfsr[29:0], lfsr[30]^lfsr[27]}; bit_cnt++.
    - abort -> IDLE, with no done. abort has priority over completion.
    - Else bit_cnt == len_q-1 -> DONE.
  - DONE (1 cycle): done = 1; next state IDLE.
- Outputs:
  - tx_valid, busy and done are decoded from state.
  - tx_bit is 0 outside RUN.
- Latency:
  - start sampled at edge T: busy high after T, first tx_valid after T+1.
  - Last bit occupies one RUN cycle; done follows in the next cycle.
  - start in DONE is ignored (not IDLE).
- Sequence: with SEED all-ones, bits 0..27 = 0 and bits 28..30 = 1. In general b[n] = b[n-31] ^ b[n-28].
- Checker:
  - Acts only on cycles with rx_valid = 1, in any state except SEED. It is not gated by busy.
  - Per rx_valid cycle: expected = hist[30] ^ hist[27]; hist <= {hist[29:0], rx_bit}.
  - fill increments, saturating at 31. locked = (fill == 31).
  - Compare only when locked is already 1 before the shift. A mismatch increments err_cnt, saturating at 2^ERR_W-1.
  - A single corrupted bit at index n yields mismatches at n, n+28 and n+31 (if received).
- Reset mid-burst returns to IDLE immediately. No done pulse.
- Error and lock status persist after DONE/IDLE until the next SEED or reset.

Decomposition:
- Shared package prbs31_pkg holds:
  - State enum (IDLE, SEED, RUN, DONE).
  - Tap constants TAP_A = 30, TAP_B = 27.
  - PRBS_LEN = 31.
  - Default SEED.
- One natural sub-module: prbs31_lfsr (load, advance, out), instanced for the generator.
- The checker history is a plain shift register in the parent.

Test Plan:
- Reset:
  - Stimulus: hold rst_n low 2 cycles with start = 1.
  - Response: all outputs 0; busy stays 0 the cycle after release unless start is still high.
- Burst 40, loopback (rx = tx, rx_valid = tx_valid):
  - busy rises the cycle after start.
  - tx_valid is high exactly 40 cycles; tx_bit is 0 for 28 bits, then 1,1,1.
  - done pulses once; locked after 31 bits; err_cnt = 0.
- Burst 100, loopback, inject_err high for bit index 40 only -> err_cnt = 3 at done (mismatches at 40, 68, 71).
- Burst 50, abort at bit index 10:
  - tx_valid drops after 11 bits; busy = 0 next cycle; done never asserts.
  - A new start then repeats the bit sequence from bit 0.
- burst_len = 0 -> done pulses 2 cycles after start; tx_valid never asserts; busy high for 2 cycles.
- Burst 400, rx_bit = ~tx_bit:
  - err_cnt = 255 (saturated, ERR_W = 8).
  - Pulse ena low for 5 mid-burst cycles: tx_valid stays high and bit sequence and count resume unchanged.

Source files
------------

// File: rtl/prbs31_pkg.sv
// PRBS31 (x^31 + x^28 + 1) shared types and constants.
// Used by the burst sequencer, its generator and the checker.
package prbs31_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SEED,
    ST_RUN,
    ST_DONE
  } state_e;

  localparam int TAP_A    = 30;
  localparam int TAP_B    = 27;
  localparam int PRBS_LEN = 31;

  localparam logic [30:0] DEFAULT_SEED = 31'h7FFF_FFFF;

  function automatic logic prbs_fb(input logic [30:0] s);
    return s[TAP_A] ^ s[TAP_B];
  endfunction

endpackage

// File: rtl/prbs31_seq_ctrl_if.sv
// Serial test-path bundle: generated stream out, looped-back stream in.
// master = sequencer side, slave = loopback / pin side.
interface prbs31_seq_ctrl_if;

  logic tx_bit;
  logic tx_valid;
  logic rx_bit;
  logic rx_valid;

  modport master (
    output tx_bit,
    output tx_valid,
    input  rx_bit,
    input  rx_valid
  );

  modport slave (
    input  tx_bit,
    input  tx_valid,
    output rx_bit,
    output rx_valid
  );

endinterface

// File: rtl/prbs31_lfsr.sv
// Fibonacci PRBS31 generator; out is the bit the next advance shifts in.
// Reset clears to zero; load must be issued before advancing.
module prbs31_lfsr
  import prbs31_pkg::*;
#(
  parameter logic [30:0] SEED = DEFAULT_SEED
) (
  input  logic clk,
  input  logic rst_n,
  input  logic ena,
  input  logic load,
  input  logic advance,
  output logic out
);

  logic [30:0] lfsr;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      lfsr <= '0;
    end else if (ena) begin
      if (load) begin
        lfsr <= SEED;
      end else if (advance) begin
        lfsr <= {lfsr[29:0], prbs_fb(lfsr)};
      end
    end
  end

  assign out = prbs_fb(lfsr);

endmodule

// File: rtl/prbs31_seq_ctrl.sv
// PRBS31 burst sequencer with self-synchronising loopback checker.
// Commands come from the pin top; tx/rx run over the loopback bundle.
module prbs31_seq_ctrl
  import prbs31_pkg::*;
#(
  parameter int          LEN_W = 16,
  parameter int          ERR_W = 8,
  parameter logic [30:0] SEED  = DEFAULT_SEED
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 ena,
  input  logic                 start,
  input  logic                 abort,
  input  logic [LEN_W-1:0]     burst_len,
  input  logic                 inject_err,
  prbs31_seq_ctrl_if.master    bus,
  output logic                 busy,
  output logic                 done,
  output logic                 locked,
  output logic [ERR_W-1:0]     err_cnt
);

  if (SEED == 31'd0) begin : g_bad_seed
    $error("prbs31_seq_ctrl: SEED must be nonzero");
  end

  state_e            state;
  state_e            state_d;
  logic [LEN_W-1:0]  len_q;
  logic [LEN_W-1:0]  bit_cnt;
  logic              lfsr_load;
  logic              lfsr_adv;
  logic              lfsr_out;
  logic              last_bit;

  logic [30:0]       hist;
  logic [4:0]        fill;
  logic [ERR_W-1:0]  err_q;
  logic              chk_act;
  logic              chk_miss;

  prbs31_lfsr #(
    .SEED    (SEED)
  ) u_gen (
    .clk     (clk),
    .rst_n   (rst_n),
    .ena     (ena),
    .load    (lfsr_load),
    .advance (lfsr_adv),
    .out     (lfsr_out)
  );

  assign last_bit = (bit_cnt == len_q - LEN_W'(1));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= ST_IDLE;
    end else if (ena) begin
      state <= state_d;
    end
  end

  always_comb begin
    state_d   = state;
    lfsr_load = 1'b0;
    lfsr_adv  = 1'b0;
    unique case (state)
      ST_IDLE: begin
        if (start) state_d = ST_SEED;
      end
      ST_SEED: begin
        lfsr_load = 1'b1;
        unique case (1'b1)
          abort:          state_d = ST_IDLE;
          (len_q == '0):  state_d = ST_DONE;
          default:        state_d = ST_RUN;
        endcase
      end
      ST_RUN: begin
        lfsr_adv = 1'b1;
        unique case (1'b1)
          abort:    state_d = ST_IDLE;
          last_bit: state_d = ST_DONE;
          default:  state_d = ST_RUN;
        endcase
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      len_q   <= '0;
      bit_cnt <= '0;
    end else if (ena) begin
      if (state == ST_IDLE && start) begin
        len_q <= burst_len;
      end
      if (state == ST_SEED) begin
        bit_cnt <= '0;
      end else if (state == ST_RUN) begin
        bit_cnt <= bit_cnt + LEN_W'(1);
      end
    end
  end

  // Checker keys off rx_valid alone so it also sees late loopback bits.
  assign chk_act  = ena && bus.rx_valid && (state != ST_SEED);
  assign chk_miss = locked && (bus.rx_bit != prbs_fb(hist));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      hist  <= '0;
      fill  <= '0;
      err_q <= '0;
    end else if (ena && state == ST_SEED) begin
      hist  <= '0;
      fill  <= '0;
      err_q <= '0;
    end else if (chk_act) begin
      hist <= {hist[29:0], bus.rx_bit};
      if (!locked) begin
        fill <= fill + 5'd1;
      end
      if (chk_miss && err_q != '1) begin
        err_q <= err_q + ERR_W'(1);
      end
    end
  end

  assign locked       = (fill == 5'(PRBS_LEN));
  assign err_cnt      = err_q;
  assign busy         = (state != ST_IDLE);
  assign done         = (state == ST_DONE);
  assign bus.tx_valid = (state == ST_RUN);
  assign bus.tx_bit   = (state == ST_RUN) ? (lfsr_out ^ inject_err) : 1'b0;

endmodule

// File: tb/tb_prbs31_seq_ctrl.sv
// Bench for prbs31_seq_ctrl: loopback bursts against a recurrence model.
// Scenarios: reset, bursts, error injection, abort, zero length, freeze.
module tb_prbs31_seq_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        ena;
  logic        start;
  logic        abort;
  logic        inject_err;
  logic [15:0] burst_len;
  logic        busy;
  logic        done;
  logic        locked;
  logic [7:0]  err_cnt;
  bit          inv_rx;

  int checks = 0;
  int errors = 0;

  prbs31_seq_ctrl_if bus();

  assign bus.rx_bit   = inv_rx ? ~bus.tx_bit : bus.tx_bit;
  assign bus.rx_valid = bus.tx_valid;

  prbs31_seq_ctrl dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .ena        (ena),
    .start      (start),
    .abort      (abort),
    .burst_len  (burst_len),
    .inject_err (inject_err),
    .bus        (bus),
    .busy       (busy),
    .done       (done),
    .locked     (locked),
    .err_cnt    (err_cnt)
  );

  always #5 clk = ~clk;

  bit ref_b [0:2047];

  bit   txq [$];
  bit   injq [$];
  int   nb;
  int   n_done;
  int   done_cyc;
  int   first_vcyc;
  int   last_vcyc;
  int   end_cyc;
  int   busy_cyc;
  int   frozen_valid;
  logic busy_at1;
  logic lock_at_done;
  logic [7:0] err_at_done;

  function automatic void build_ref();
    for (int n = 0; n < 2048; n++) begin
      if (n < 28)      ref_b[n] = 1'b0;
      else if (n < 31) ref_b[n] = 1'b1;
      else             ref_b[n] = ref_b[n-31] ^ ref_b[n-28];
    end
  endfunction

  // Expected saturating mismatch count over a received stream.
  function automatic int model_err(input bit q[$]);
    int c = 0;
    for (int k = 31; k < q.size(); k++) begin
      if (q[k] != (q[k-31] ^ q[k-28])) c++;
    end
    return (c > 255) ? 255 : c;
  endfunction

  function automatic int tx_mismatches();
    int m = 0;
    foreach (txq[i]) begin
      if (txq[i] !== (ref_b[i] ^ injq[i])) m++;
    end
    return m;
  endfunction

  // rnd[0]: random ena drops, rnd[1]: random bit injection.
  task automatic drive_burst(input int len, input int inj_idx,
                             input int abort_idx, input int pause_at,
                             input int pause_n, input int rnd);
    int  cyc;
    int  lowleft;
    bit  paused;
    txq.delete();
    injq.delete();
    nb = 0; n_done = 0; done_cyc = -1; first_vcyc = -1;
    last_vcyc = -1; end_cyc = -1; busy_cyc = 0; frozen_valid = 0;
    lock_at_done = 1'b0; err_at_done = '0; busy_at1 = 1'b0;
    lowleft = 0; paused = 0;
    start = 1'b1; burst_len = 16'(len); ena = 1'b1;
    inject_err = 1'b0; abort = 1'b0;
    #1;
    @(posedge clk); #1;
    start = 1'b0;
    cyc = 1;
    while (1) begin
      if (cyc > len + 400) begin
        checks++; errors++;
        $display("FAIL burst_timeout len=%0d got busy=%b want idle", len, busy);
        break;
      end
      if (bus.tx_valid && nb == pause_at && !paused) begin
        paused = 1; lowleft = pause_n;
      end
      if (lowleft > 0) begin
        ena = 1'b0; lowleft--;
      end else if (rnd[0] && $urandom_range(0, 4) == 0) begin
        ena = 1'b0;
      end else begin
        ena = 1'b1;
      end
      inject_err = (nb == inj_idx) ||
                   (rnd[1] && $urandom_range(0, 15) == 0);
      abort = bus.tx_valid && (nb == abort_idx);
      #1;
      if (cyc == 1) busy_at1 = busy;
      if (!busy) begin
        end_cyc = cyc;
        break;
      end
      if (ena) busy_cyc++;
      if (bus.tx_valid && first_vcyc < 0) first_vcyc = cyc;
      if (!ena && bus.tx_valid) frozen_valid++;
      if (ena && done) begin
        n_done++; done_cyc = cyc;
        err_at_done = err_cnt; lock_at_done = locked;
      end
      if (ena && bus.tx_valid) begin
        txq.push_back(bus.tx_bit);
        injq.push_back(inject_err);
        nb++;
        last_vcyc = cyc;
      end
      @(posedge clk); #1;
      cyc++;
    end
    ena = 1'b1; inject_err = 1'b0; abort = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({busy, done, locked, err_cnt, bus.tx_valid, bus.tx_bit} !== '0) begin
      errors++;
      $display("FAIL reset_outputs got b%b d%b l%b e%0d v%b t%b want 0",
               busy, done, locked, err_cnt, bus.tx_valid, bus.tx_bit);
    end
    start = 1'b0; rst_n = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_release_busy got %b want 0", busy);
    end
  endtask

  task automatic test_burst40();
    int head;
    drive_burst(40, -1, -1, -1, 0, 0);
    checks++;
    if (busy_at1 !== 1'b1 || first_vcyc != 2) begin
      errors++;
      $display("FAIL b40_latency got busy1=%b vcyc=%0d want 1/2",
               busy_at1, first_vcyc);
    end
    checks++;
    if (nb != 40) begin
      errors++;
      $display("FAIL b40_valid_count got %0d want 40", nb);
    end
    head = 0;
    for (int i = 0; i < 31 && i < txq.size(); i++) head = head * 2 + txq[i];
    checks++;
    if (head != 7) begin
      errors++;
      $display("FAIL b40_head got %0h want 7", head);
    end
    checks++;
    if (tx_mismatches() != 0) begin
      errors++;
      $display("FAIL b40_bits got %0d bad bits want 0", tx_mismatches());
    end
    checks++;
    if (n_done != 1 || done_cyc != 42) begin
      errors++;
      $display("FAIL b40_done got n=%0d cyc=%0d want 1/42", n_done, done_cyc);
    end
    checks++;
    if (lock_at_done !== 1'b1 || err_at_done !== 8'd0) begin
      errors++;
      $display("FAIL b40_lock_err got l=%b e=%0d want 1/0",
               lock_at_done, err_at_done);
    end
  endtask

  task automatic test_inject();
    drive_burst(100, 40, -1, -1, 0, 0);
    checks++;
    if (err_at_done !== 8'd3) begin
      errors++;
      $display("FAIL inj_err got %0d want 3", err_at_done);
    end
    checks++;
    if (tx_mismatches() != 0 || nb != 100) begin
      errors++;
      $display("FAIL inj_bits got bad=%0d n=%0d want 0/100",
               tx_mismatches(), nb);
    end
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (err_cnt !== 8'd3 || locked !== 1'b1) begin
      errors++;
      $display("FAIL inj_persist got e=%0d l=%b want 3/1", err_cnt, locked);
    end
  endtask

  task automatic test_abort();
    drive_burst(50, -1, 10, -1, 0, 0);
    checks++;
    if (nb != 11 || n_done != 0) begin
      errors++;
      $display("FAIL abort_count got n=%0d done=%0d want 11/0", nb, n_done);
    end
    checks++;
    if (end_cyc != last_vcyc + 1) begin
      errors++;
      $display("FAIL abort_idle got end=%0d want %0d", end_cyc, last_vcyc + 1);
    end
    drive_burst(20, -1, -1, -1, 0, 0);
    checks++;
    if (nb != 20 || tx_mismatches() != 0 || n_done != 1) begin
      errors++;
      $display("FAIL abort_restart got n=%0d bad=%0d done=%0d want 20/0/1",
               nb, tx_mismatches(), n_done);
    end
  endtask

  task automatic test_len0();
    drive_burst(0, -1, -1, -1, 0, 0);
    checks++;
    if (n_done != 1 || done_cyc != 2) begin
      errors++;
      $display("FAIL len0_done got n=%0d cyc=%0d want 1/2", n_done, done_cyc);
    end
    checks++;
    if (nb != 0 || busy_cyc != 2) begin
      errors++;
      $display("FAIL len0_shape got valid=%0d busy=%0d want 0/2", nb, busy_cyc);
    end
  endtask

  task automatic test_invert_freeze();
    inv_rx = 1'b1;
    drive_burst(400, -1, -1, 100, 5, 0);
    inv_rx = 1'b0;
    checks++;
    if (err_at_done !== 8'd255) begin
      errors++;
      $display("FAIL inv_sat got %0d want 255", err_at_done);
    end
    checks++;
    if (frozen_valid != 5 || nb != 400 || tx_mismatches() != 0) begin
      errors++;
      $display("FAIL freeze got fv=%0d n=%0d bad=%0d want 5/400/0",
               frozen_valid, nb, tx_mismatches());
    end
  endtask

  task automatic test_random();
    int len;
    bit rq [$];
    for (int it = 0; it < 4; it++) begin
      len = $urandom_range(31, 200);
      drive_burst(len, -1, -1, -1, 0, 3);
      rq.delete();
      for (int i = 0; i < len; i++) rq.push_back(ref_b[i] ^ injq[i]);
      checks++;
      if (nb != len || tx_mismatches() != 0 || n_done != 1) begin
        errors++;
        $display("FAIL rnd_tx it=%0d got n=%0d bad=%0d done=%0d want %0d/0/1",
                 it, nb, tx_mismatches(), n_done, len);
      end
      checks++;
      if (int'(err_at_done) != model_err(rq) || lock_at_done !== 1'b1) begin
        errors++;
        $display("FAIL rnd_err it=%0d got e=%0d l=%b want %0d/1",
                 it, err_at_done, lock_at_done, model_err(rq));
      end
    end
  endtask

  task automatic test_reset_mid();
    int saw_done = 0;
    start = 1'b1; burst_len = 16'd100;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (40) begin
      @(posedge clk); #1;
    end
    rst_n = 1'b0;
    @(posedge clk); #1;
    if (done) saw_done++;
    rst_n = 1'b1;
    @(posedge clk); #1;
    if (done) saw_done++;
    checks++;
    if (busy !== 1'b0 || bus.tx_valid !== 1'b0 || saw_done != 0 ||
        locked !== 1'b0 || err_cnt !== 8'd0) begin
      errors++;
      $display("FAIL reset_mid got b=%b v=%b d=%0d l=%b e=%0d want 0",
               busy, bus.tx_valid, saw_done, locked, err_cnt);
    end
  endtask

  initial begin
    rst_n = 1'b0; ena = 1'b1; start = 1'b0; abort = 1'b0;
    inject_err = 1'b0; burst_len = '0; inv_rx = 1'b0;
    build_ref();
    test_reset();
    test_burst40();
    test_inject();
    test_abort();
    test_len0();
    test_invert_freeze();
    test_random();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
